// File: rtl/sram_uart_ctrl_if.sv
// CPU-side data port and instruction-fetch port
// of the SRAM/UART controller.
interface sram_uart_ctrl_if;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_valid;

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_addr,
    input  d_rdata, d_ready, d_err, i_data, i_valid
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_addr,
    output d_rdata, d_ready, d_err, i_data, i_valid
  );
endinterface

// File: rtl/sram_uart_ctrl.sv
// Shared SRAM/UART bus controller: data port to RAM1/RAM2/UART,
// fetch path on RAM2 stalled to a NOP during RAM2 data accesses.
module sram_uart_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] SYS_TOP     = 16'h4000,
  parameter logic [15:0] UART_BASE   = 16'hBF00,
  parameter logic [15:0] NOP_WORD    = 16'h0800
) (
  input  logic        CLK,
  input  logic        RST,
  sram_uart_ctrl_if.slave bus,
  output logic [17:0] ram1_addr,
  input  logic [15:0] ram1_dq_i,
  output logic [15:0] ram1_dq_o,
  output logic        ram1_dq_oe,
  output logic        ram1_ce_n,
  output logic        ram1_oe_n,
  output logic        ram1_we_n,
  output logic [17:0] ram2_addr,
  input  logic [15:0] ram2_dq_i,
  output logic [15:0] ram2_dq_o,
  output logic        ram2_dq_oe,
  output logic        ram2_ce_n,
  output logic        ram2_oe_n,
  output logic        ram2_we_n,
  output logic        rdn,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, QUICK
  } state_t;

  typedef enum logic [1:0] {
    T_RAM1, T_RAM2, T_UART
  } tgt_t;

  state_t      state, next;
  tgt_t        tgt_q, tgt_d;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        we_q, err_q;
  logic [3:0]  cnt;
  logic        is_uart, prot, quick, accept;
  logic        act, stb, busy2;
  logic        r1, r2, ua;

  // Address decode and fast-path classification of the request
  always_comb begin
    is_uart = bus.d_addr[15] &&
              (bus.d_addr[15:4] == UART_BASE[15:4]);
    tgt_d   = T_RAM1;
    if (!bus.d_addr[15])
      tgt_d = T_RAM2;
    else if (is_uart)
      tgt_d = T_UART;
    prot    = bus.d_we && (bus.d_addr < SYS_TOP);
    quick   = prot || (is_uart && bus.d_addr[3:0] != 4'd0);
    accept  = (state == IDLE) && bus.d_req;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.d_req) next = quick ? QUICK : SETUP;
      SETUP:   next = STROBE;
      STROBE:  if (cnt <= 4'd1) next = HOLD;
      HOLD:    next = IDLE;
      QUICK:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Request latch, strobe counter and read-data capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      tgt_q   <= T_RAM1;
    end else begin
      if (accept) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        we_q    <= bus.d_we;
        tgt_q   <= tgt_d;
        err_q   <= prot;
        if (quick && !bus.d_we)
          rdata_q <= (bus.d_addr[3:0] == 4'd1) ?
                     {14'b0, data_ready, tbre & tsre} :
                     16'h0000;
      end
      if (state == SETUP)
        cnt <= 4'(WAIT_CYCLES);
      else if (state == STROBE) begin
        cnt <= cnt - 4'd1;
        if (cnt <= 4'd1 && !we_q) begin
          unique case (tgt_q)
            T_RAM2:  rdata_q <= ram2_dq_i;
            T_UART:  rdata_q <= {8'h00, ram1_dq_i[7:0]};
            default: rdata_q <= ram1_dq_i;
          endcase
        end
      end
    end
  end

  assign act   = state inside {SETUP, STROBE, HOLD};
  assign stb   = (state == STROBE);
  assign r1    = (tgt_q == T_RAM1);
  assign r2    = (tgt_q == T_RAM2);
  assign ua    = (tgt_q == T_UART);
  assign busy2 = act && r2;

  assign ram1_addr  = {2'b00, addr_q};
  assign ram1_dq_o  = wdata_q;
  assign ram1_dq_oe = act && (r1 || ua) && we_q;
  assign ram1_ce_n  = !(act && r1);
  assign ram1_oe_n  = !(stb && r1 && !we_q);
  assign ram1_we_n  = !(stb && r1 && we_q);

  assign rdn = !(stb && ua && !we_q);
  assign wrn = !(stb && ua && we_q);

  assign ram2_addr  = {2'b00, busy2 ? addr_q : bus.i_addr};
  assign ram2_dq_o  = wdata_q;
  assign ram2_dq_oe = busy2 && we_q;
  assign ram2_ce_n  = 1'b0;
  assign ram2_oe_n  = busy2 ? !(stb && !we_q) : 1'b0;
  assign ram2_we_n  = !(busy2 && stb && we_q);

  assign bus.d_ready = (state == HOLD) || (state == QUICK);
  assign bus.d_err   = (state == QUICK) && err_q;
  assign bus.d_rdata = rdata_q;
  assign bus.i_data  = busy2 ? NOP_WORD : ram2_dq_i;
  assign bus.i_valid = !busy2;

endmodule

// File: tb/tb_sram_uart_ctrl.sv
// Directed bench for sram_uart_ctrl: expected completions go to a
// queue, a negedge monitor pops and compares them on d_ready.
module tb_sram_uart_ctrl;

  typedef struct {
    logic [15:0] rd;
    logic        chk_rd;
    logic        err;
    int          lat;
    int          t0;
    logic [15:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic RST3 = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   r3_ready = 0;
  exp_t sb[$];
  exp_t m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sram_uart_ctrl_if bus ();
  sram_uart_ctrl_if bus3 ();

  logic [17:0] ram1_addr, ram2_addr;
  logic [15:0] ram1_dq_i, ram1_dq_o, ram2_dq_i, ram2_dq_o;
  logic ram1_dq_oe, ram1_ce_n, ram1_oe_n, ram1_we_n;
  logic ram2_dq_oe, ram2_ce_n, ram2_oe_n, ram2_we_n;
  logic rdn, wrn;
  logic tbre = 1'b1, tsre = 1'b0, data_ready = 1'b1;

  logic [17:0] a1_3, a2_3;
  logic [15:0] o1_3, o2_3;
  logic [15:0] zero16 = 16'h0000;
  logic oe1_3, ce1_3, rn1_3, wn1_3;
  logic oe2_3, ce2_3, rn2_3, wn2_3;
  logic rdn3, wrn3;

  sram_uart_ctrl dut (
    .CLK(clk), .RST(RST), .bus(bus),
    .ram1_addr(ram1_addr), .ram1_dq_i(ram1_dq_i),
    .ram1_dq_o(ram1_dq_o), .ram1_dq_oe(ram1_dq_oe),
    .ram1_ce_n(ram1_ce_n), .ram1_oe_n(ram1_oe_n),
    .ram1_we_n(ram1_we_n),
    .ram2_addr(ram2_addr), .ram2_dq_i(ram2_dq_i),
    .ram2_dq_o(ram2_dq_o), .ram2_dq_oe(ram2_dq_oe),
    .ram2_ce_n(ram2_ce_n), .ram2_oe_n(ram2_oe_n),
    .ram2_we_n(ram2_we_n),
    .rdn(rdn), .wrn(wrn), .tbre(tbre), .tsre(tsre),
    .data_ready(data_ready)
  );

  sram_uart_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .CLK(clk), .RST(RST3), .bus(bus3),
    .ram1_addr(a1_3), .ram1_dq_i(zero16),
    .ram1_dq_o(o1_3), .ram1_dq_oe(oe1_3),
    .ram1_ce_n(ce1_3), .ram1_oe_n(rn1_3),
    .ram1_we_n(wn1_3),
    .ram2_addr(a2_3), .ram2_dq_i(zero16),
    .ram2_dq_o(o2_3), .ram2_dq_oe(oe2_3),
    .ram2_ce_n(ce2_3), .ram2_oe_n(rn2_3),
    .ram2_we_n(wn2_3),
    .rdn(rdn3), .wrn(wrn3), .tbre(tbre), .tsre(tsre),
    .data_ready(data_ready)
  );

  // SRAM models: asynchronous read, write while we_n is low
  logic [15:0] mem1 [logic [15:0]];
  logic [15:0] mem2 [logic [15:0]];
  int m_tick = 0;

  function automatic logic [15:0] rd1(input logic [15:0] a);
    return mem1.exists(a) ? mem1[a] : (a ^ 16'hC3C3);
  endfunction

  function automatic logic [15:0] rd2(input logic [15:0] a);
    return mem2.exists(a) ? mem2[a] : (a ^ 16'h5A5A);
  endfunction

  always @(ram1_addr or m_tick) ram1_dq_i = rd1(ram1_addr[15:0]);
  always @(ram2_addr or m_tick) ram2_dq_i = rd2(ram2_addr[15:0]);

  int c_r1oe = 0, c_r1we = 0, c_r1ce = 0;
  int c_r2we = 0, c_rdn = 0, c_wrn = 0;
  int s_r1oe, s_r1we, s_r1ce, s_r2we, s_rdn, s_wrn;

  always @(negedge clk) begin
    if (!ram1_we_n) begin
      mem1[ram1_addr[15:0]] = ram1_dq_o;
      m_tick = m_tick + 1;
    end
    if (!ram2_we_n) begin
      mem2[ram2_addr[15:0]] = ram2_dq_o;
      m_tick = m_tick + 1;
    end
    if (!ram1_oe_n) c_r1oe++;
    if (!ram1_we_n) c_r1we++;
    if (!ram1_ce_n) c_r1ce++;
    if (!ram2_we_n) c_r2we++;
    if (!rdn) c_rdn++;
    if (!wrn) c_wrn++;
    if (bus3.d_ready === 1'b1) r3_ready++;
  end

  // Response monitor
  always @(negedge clk) begin
    if (bus.d_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready rdata=%h", bus.d_rdata);
      end else begin
        m_e = sb.pop_front();
        checks++;
        if (cyc - m_e.t0 != m_e.lat) begin
          errors++;
          $display("FAIL latency addr=%h got=%0d exp=%0d",
                   m_e.tag, cyc - m_e.t0, m_e.lat);
        end
        checks++;
        if (bus.d_err !== m_e.err) begin
          errors++;
          $display("FAIL d_err addr=%h got=%b exp=%b",
                   m_e.tag, bus.d_err, m_e.err);
        end
        if (m_e.chk_rd) begin
          checks++;
          if (bus.d_rdata !== m_e.rd) begin
            errors++;
            $display("FAIL d_rdata addr=%h got=%h exp=%h",
                     m_e.tag, bus.d_rdata, m_e.rd);
          end
        end
      end
      done_cnt++;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic snap();
    s_r1oe = c_r1oe; s_r1we = c_r1we; s_r1ce = c_r1ce;
    s_r2we = c_r2we; s_rdn = c_rdn; s_wrn = c_wrn;
  endtask

  task automatic issue(input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] rd,
                       input logic chk_rd, input logic err,
                       input int lat, input logic r2busy);
    exp_t e;
    int   d0;
    int   bad;
    logic got;
    e.rd = rd; e.chk_rd = chk_rd; e.err = err;
    e.lat = lat; e.tag = a;
    @(negedge clk);
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
    e.t0 = cyc;
    sb.push_back(e);
    d0 = done_cnt;
    bad = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 0) bus.d_req = 1'b0;
      #1;
      if (r2busy && (bus.i_valid !== 1'b0 ||
                     bus.i_data !== 16'h0800)) bad++;
      if (done_cnt != d0) got = 1'b1;
    end
    chk("completion", 32'(got), 32'd1);
    if (r2busy) begin
      chk("fetch_stall", bad, 0);
      @(negedge clk);
      #1;
      chk("fetch_resume_valid", 32'(bus.i_valid), 32'd1);
      chk("fetch_resume_data", 32'(bus.i_data),
          32'(rd2(bus.i_addr)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
    bus.i_addr = 16'h0123;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = 16'h0; bus3.d_wdata = 16'h0;
    bus3.i_addr = 16'h0;
    mem1[16'h8010] = 16'hA5A5;
    mem1[16'hBF00] = 16'h3C41;
    m_tick = 1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_err", 32'(bus.d_err), 32'd0);
    chk("rst_rdata", 32'(bus.d_rdata), 32'h0);
    chk("rst_ram1_ctl",
        32'({ram1_ce_n, ram1_oe_n, ram1_we_n, ram1_dq_oe}),
        32'b1110);
    chk("rst_uart", 32'({rdn, wrn}), 32'b11);
    chk("rst_ram2_ctl",
        32'({ram2_ce_n, ram2_oe_n, ram2_we_n, ram2_dq_oe}),
        32'b0010);
    RST = 1'b0;
    RST3 = 1'b0;
    @(negedge clk);
    chk("fetch_valid", 32'(bus.i_valid), 32'd1);
    chk("fetch_addr", 32'(ram2_addr), 32'h00123);
    chk("fetch_data", 32'(bus.i_data), 32'(16'h0123 ^ 16'h5A5A));

    // RAM1 read
    snap();
    issue(1'b0, 16'h8010, 16'h0, 16'hA5A5, 1'b1, 1'b0, 3, 1'b0);
    chk("r1_oe_cycles", c_r1oe - s_r1oe, 1);
    chk("r1_ce_cycles", c_r1ce - s_r1ce, 3);
    chk("r1_we_cycles", c_r1we - s_r1we, 0);

    // RAM2 write
    snap();
    issue(1'b1, 16'h5000, 16'h1234, 16'h0, 1'b0, 1'b0, 3, 1'b1);
    chk("r2_we_cycles", c_r2we - s_r2we, 1);
    chk("r2_mem_5000", 32'(rd2(16'h5000)), 32'h1234);
    chk("r2_write_r1ce", c_r1ce - s_r1ce, 0);

    // protected write
    snap();
    issue(1'b1, 16'h0100, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1, 1'b0);
    chk("prot_we_cycles", c_r2we - s_r2we + c_r1we - s_r1we, 0);
    chk("prot_mem_0100", 32'(mem2.exists(16'h0100)), 32'd0);

    // UART status read
    snap();
    issue(1'b0, 16'hBF01, 16'h0, 16'h0002, 1'b1, 1'b0, 1, 1'b0);
    chk("status_rdn", c_rdn - s_rdn, 0);

    // UART data write and read
    snap();
    issue(1'b1, 16'hBF00, 16'h0041, 16'h0, 1'b0, 1'b0, 3, 1'b0);
    chk("uart_wr_wrn", c_wrn - s_wrn, 1);
    chk("uart_wr_ce", c_r1ce - s_r1ce, 0);
    chk("uart_wr_r1we", c_r1we - s_r1we, 0);
    snap();
    issue(1'b0, 16'hBF00, 16'h0, 16'h0041, 1'b1, 1'b0, 3, 1'b0);
    chk("uart_rd_rdn", c_rdn - s_rdn, 1);
    chk("uart_rd_wrn", c_wrn - s_wrn, 0);
    chk("uart_rd_ce", c_r1ce - s_r1ce, 0);

    // RAM2 read back, RAM1 write and read back
    issue(1'b0, 16'h5000, 16'h0, 16'h1234, 1'b1, 1'b0, 3, 1'b1);
    snap();
    issue(1'b1, 16'h9000, 16'hBEEF, 16'h0, 1'b0, 1'b0, 3, 1'b0);
    chk("r1_wr_we", c_r1we - s_r1we, 1);
    chk("r1_mem_9000", 32'(rd1(16'h9000)), 32'hBEEF);
    issue(1'b0, 16'h9000, 16'h0, 16'hBEEF, 1'b1, 1'b0, 3, 1'b0);

    // other UART offset
    snap();
    issue(1'b0, 16'hBF05, 16'h0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    chk("uart_other_rdn", c_rdn - s_rdn, 0);

    // protection boundary
    issue(1'b1, 16'h4000, 16'h7777, 16'h0, 1'b0, 1'b0, 3, 1'b1);
    chk("r2_mem_4000", 32'(rd2(16'h4000)), 32'h7777);
    issue(1'b1, 16'h3FFF, 16'h6666, 16'h0, 1'b0, 1'b1, 1, 1'b0);
    chk("prot_mem_3fff", 32'(mem2.exists(16'h3FFF)), 32'd0);

    // request during an access is ignored
    begin
      exp_t e;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0;
      bus.d_addr = 16'h8010;
      e.rd = 16'hA5A5; e.chk_rd = 1'b1; e.err = 1'b0;
      e.lat = 3; e.t0 = cyc; e.tag = 16'h8010;
      sb.push_back(e);
      d0 = done_cnt;
      @(negedge clk);
      bus.d_addr = 16'h9000;
      @(negedge clk);
      bus.d_req = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("busy_req_ignored", done_cnt - d0, 1);
    end

    // reset in the middle of a WAIT_CYCLES=3 UART write
    @(negedge clk);
    bus3.d_req = 1'b1; bus3.d_we = 1'b1;
    bus3.d_addr = 16'hBF00; bus3.d_wdata = 16'h0041;
    @(negedge clk);
    bus3.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("w3_wrn_strobe", 32'(wrn3), 32'd0);
    RST3 = 1'b1;
    @(negedge clk);
    RST3 = 1'b0;
    #1;
    chk("w3_wrn_after_rst", 32'(wrn3), 32'd1);
    chk("w3_dq_oe_after_rst", 32'(oe1_3), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("w3_no_ready", r3_ready, 0);
    bus3.d_req = 1'b1; bus3.d_we = 1'b0;
    bus3.d_addr = 16'hBF01;
    @(negedge clk);
    bus3.d_req = 1'b0;
    #1;
    chk("w3_idle_quick_ready", 32'(bus3.d_ready), 32'd1);
    chk("w3_status", 32'(bus3.d_rdata), 32'h0002);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
